// File: rtl/fifo_buffer_pkg.sv
// Shared types and constants for the fifo_buffer block.
// Pointer width helper and the flag values presented while reset is asserted.
package fifo_buffer_pkg;

    // One extra pointer bit distinguishes a full FIFO from an empty one.
    function automatic int ptr_width(input int depth_bits);
        return depth_bits + 1;
    endfunction

    localparam logic EMPTY_RST = 1'b1;
    localparam logic FULL_RST  = 1'b0;

endpackage

// File: rtl/fifo_buffer_if.sv
// Producer/consumer handshake bundle for fifo_buffer.
// The count signal exists only when FIFO_BUFFER_COUNT_EN is defined.
interface fifo_buffer_if
    import fifo_buffer_pkg::*;
#(
`ifdef FIFO_BUFFER_COUNT_EN
    parameter int DEPTH_BITS = 3,
`endif
    parameter int DATA_WIDTH = 8
);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
`ifdef FIFO_BUFFER_COUNT_EN
    logic [ptr_width(DEPTH_BITS)-1:0] count;
`endif

    // master: the user side driving requests; slave: the FIFO itself.
    modport master (
        output wr_en,
        output wr_data,
        output rd_en,
        input  rd_data,
        input  full,
`ifdef FIFO_BUFFER_COUNT_EN
        input  count,
`endif
        input  empty
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  rd_en,
        output rd_data,
        output full,
`ifdef FIFO_BUFFER_COUNT_EN
        output count,
`endif
        output empty
    );

endinterface

// File: rtl/fifo_buffer_mem.sv
// Storage array for fifo_buffer: one synchronous write port, one read port.
// Contents are never reset; the read value is registered by the parent.
module fifo_buffer_mem #(
    parameter int DEPTH_BITS = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_BITS-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DEPTH_BITS-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** DEPTH_BITS;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_buffer.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Define FIFO_BUFFER_COUNT_EN to expose an occupancy count on the interface.
module fifo_buffer
    import fifo_buffer_pkg::*;
#(
    parameter int DEPTH_BITS = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    fifo_buffer_if.slave   bus
);

    localparam int PW = ptr_width(DEPTH_BITS);

    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         rd_ptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  empty_dec;
    logic                  full_dec;
    logic                  rd_acc;
    logic                  wr_acc;

    // Same slot index with opposite wrap bits means the writer is a lap ahead.
    assign empty_dec = (wr_ptr_q == rd_ptr_q);
    assign full_dec  = (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]) &&
                       (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]);

    // A read in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign rd_acc = bus.rd_en & ~empty_dec;
    assign wr_acc = bus.wr_en & (~full_dec | rd_acc);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            rd_data_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    fifo_buffer_mem #(
        .DEPTH_BITS (DEPTH_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q[DEPTH_BITS-1:0]),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_q[DEPTH_BITS-1:0]),
        .rdata (mem_rdata)
    );

    assign bus.rd_data = rd_data_q;
    assign bus.empty   = reset ? empty_dec : EMPTY_RST;
    assign bus.full    = reset ? full_dec  : FULL_RST;

`ifdef FIFO_BUFFER_COUNT_EN
    // Modulo subtraction yields 0..2**DEPTH_BITS across pointer wraps.
    assign bus.count = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// Self-checking bench for fifo_buffer: directed scenarios then randomized traffic
// compared against a queue-based reference model.
module tb_fifo_buffer;

    localparam int DB    = 3;
    localparam int DW    = 4;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    fifo_buffer_if #(
`ifdef FIFO_BUFFER_COUNT_EN
        .DEPTH_BITS (DB),
`endif
        .DATA_WIDTH (DW)
    ) bus ();

    fifo_buffer #(
        .DEPTH_BITS (DB),
        .DATA_WIDTH (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int unsigned model_q[$];
    int unsigned exp_rd = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "/rd_data"}, 32'(bus.rd_data), exp_rd);
        check({tag, "/empty"},   32'(bus.empty), (model_q.size() == 0) ? 32'd1 : 32'd0);
        check({tag, "/full"},    32'(bus.full),  (model_q.size() == DEPTH) ? 32'd1 : 32'd0);
`ifdef FIFO_BUFFER_COUNT_EN
        check({tag, "/count"},   32'(bus.count), 32'(model_q.size()));
`endif
    endtask

    // One clock of traffic: drive, let the edge happen, advance the model, compare.
    task automatic step(input bit we, input logic [3:0] wd, input bit re, input string tag);
        bit rd_ok;
        bit wr_ok;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        @(posedge clk);
        rd_ok = re && (model_q.size() != 0);
        wr_ok = we && ((model_q.size() < DEPTH) || rd_ok);
        if (rd_ok) exp_rd = model_q.pop_front();
        if (wr_ok) model_q.push_back(32'(wd));
        #1;
        $display("%0t %s we=%0d wd=%h re=%0d -> rd_data=%h empty=%0d full=%0d",
                 $time, tag, we, wd, re, bus.rd_data, bus.empty, bus.full);
        check_status(tag);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;

        // Reset held low for 20 ns, released between edges.
        #2;
        check_status("reset_hold");
        #18;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_status("reset_release");

        // Write F, 4 then three reads; the third finds the FIFO empty.
        step(1'b1, 4'hF, 1'b0, "wr_F");
        step(1'b1, 4'h4, 1'b0, "wr_4");
        step(1'b0, 4'h0, 1'b1, "rd_1");
        step(1'b0, 4'h0, 1'b1, "rd_2");
        step(1'b0, 4'h0, 1'b1, "rd_empty");

        // Read and write together on an empty FIFO: the read is ignored.
        step(1'b1, 4'h9, 1'b1, "wr_rd_empty");
        step(1'b0, 4'h0, 1'b1, "rd_9");

        // Write 6, then write A while reading 6.
        step(1'b1, 4'h6, 1'b0, "wr_6");
        step(1'b1, 4'hA, 1'b1, "wr_A_rd_6");
        step(1'b0, 4'h0, 1'b1, "rd_A");

        // Fill, overflow attempt, then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 4'(i), 1'b0, "fill");
        step(1'b1, 4'hC, 1'b0, "overflow");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 4'h0, 1'b1, "drain");
        step(1'b0, 4'h0, 1'b1, "underflow");

        // Full FIFO with simultaneous read and write.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 4'(i + 5), 1'b0, "refill");
        step(1'b1, 4'hE, 1'b1, "full_wr_rd");
        step(1'b1, 4'h3, 1'b1, "full_wr_rd2");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 4'h0, 1'b1, "drain2");

        // Twenty write/read pairs to wrap the pointers.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'(i * 7 + 1), 1'b0, "wrap_wr");
            step(1'b0, 4'h0, 1'b1, "wrap_rd");
        end

        // Leave data in the FIFO, then pulse reset between clock edges.
        step(1'b1, 4'h5, 1'b0, "pre_rst_wr");
        step(1'b1, 4'hB, 1'b0, "pre_rst_wr");
        step(1'b1, 4'h2, 1'b1, "pre_rst_wr_rd");
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        model_q.delete();
        exp_rd = 0;
        check_status("async_reset");
        #1;
        reset = 1'b1;
        step(1'b0, 4'h0, 1'b1, "post_rst_rd");

        // Randomized traffic: write-heavy then read-heavy to visit both flags.
        for (int i = 0; i < 300; i++) begin
            bit we;
            bit re;
            if (i < 150) begin
                we = ($urandom_range(0, 3) != 0);
                re = ($urandom_range(0, 3) == 0);
            end else begin
                we = ($urandom_range(0, 3) == 0);
                re = ($urandom_range(0, 3) != 0);
            end
            step(we, 4'($urandom), re, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
